// File: rtl/data_mem_responder_if.sv
// Data-memory request/response bus between the pipeline MEM stage (master)
// and the fixed-latency data-memory responder (slave).
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency handshaked data memory for the LEGv8 MEM stage.
// One doubleword load/store in flight at a time; a single-cycle response
// arrives LATENCY cycles after acceptance, flagging misaligned or
// out-of-range addresses. Array contents survive reset.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 128,
  parameter int LATENCY     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic             r_write;
  logic [63:0]      r_addr;
  logic [63:0]      r_wdata;
  logic [63:0]      r_rdata;
  logic             r_err;
  logic [63:0]      r_mem [DEPTH_WORDS];

  logic             w_accept;
  logic             w_enter_resp;
  logic             w_op_write;
  logic [63:0]      w_op_addr;
  logic [63:0]      w_op_wdata;
  logic [IDX_W-1:0] w_idx;
  logic             w_err;

  assign bus.req_ready  = (r_state == IDLE) & ~reset;
  assign w_accept       = bus.req_valid & bus.req_ready;

  // Entering RESP straight from IDLE (LATENCY==1) happens on the accept edge,
  // before the capture registers hold the request, so use the live bus then.
  assign w_op_write     = (r_state == IDLE) ? bus.req_write : r_write;
  assign w_op_addr      = (r_state == IDLE) ? bus.req_addr  : r_addr;
  assign w_op_wdata     = (r_state == IDLE) ? bus.req_wdata : r_wdata;

  assign w_idx          = w_op_addr[IDX_W+2:3];
  assign w_err          = (w_op_addr[2:0] != 3'b000) | (|w_op_addr[63:IDX_W+3]);

  assign bus.resp_valid = (r_state == RESP);
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;
  assign bus.busy       = (r_state != IDLE);

  // Next-state and latency counter: IDLE -> (WAIT ->) RESP -> IDLE.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_enter_resp = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (LATENCY == 1) begin
            w_state_nxt  = RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        w_cnt_nxt = r_cnt - CNT_ONE;
        if (r_cnt == CNT_ONE) begin
          w_state_nxt  = RESP;
          w_enter_resp = 1'b1;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and counter registers; reset aborts any request in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Capture the request at acceptance so the requester may move on.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_write <= bus.req_write;
      r_addr  <= bus.req_addr;
      r_wdata <= bus.req_wdata;
    end
  end

  // Response data/error: loaded entering RESP, cleared when leaving it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_enter_resp) begin
      r_err   <= w_err;
      r_rdata <= (!w_op_write && !w_err) ? r_mem[w_idx] : 64'd0;
    end else if (r_state == RESP) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end
  end

  // Store commit: only clean writes reach the array, on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (w_enter_resp && w_op_write && !w_err) begin
      r_mem[w_idx] <= w_op_wdata;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a LATENCY=2 and a LATENCY=1 instance, a
// reference memory model and an expected-response queue.
module tb_data_mem_responder;

  localparam int DEPTH = 128;

  logic clk = 1'b0;
  logic rst2;
  logic rst1;
  always #5 clk = ~clk;

  data_mem_responder_if bus2 ();
  data_mem_responder_if bus1 ();

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut2 (
    .clk(clk), .reset(rst2), .bus(bus2)
  );
  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
    .clk(clk), .reset(rst1), .bus(bus1)
  );

  typedef struct packed {
    logic        err;
    logic [63:0] rdata;
  } exp_t;

  typedef struct {
    int          sel;
    logic        w;
    logic [63:0] a;
    logic [63:0] d;
  } req_t;

  exp_t        sb [$];
  logic [63:0] model [2][DEPTH];
  int          n_checks;
  int          n_errors;

  function automatic req_t mk(int sel, logic w, logic [63:0] a, logic [63:0] d);
    req_t r;
    r.sel = sel; r.w = w; r.a = a; r.d = d;
    return r;
  endfunction

  function automatic logic get_valid(int sel);
    return (sel == 1) ? bus1.resp_valid : bus2.resp_valid;
  endfunction
  function automatic logic get_ready(int sel);
    return (sel == 1) ? bus1.req_ready : bus2.req_ready;
  endfunction
  function automatic logic get_busy(int sel);
    return (sel == 1) ? bus1.busy : bus2.busy;
  endfunction
  function automatic logic get_err(int sel);
    return (sel == 1) ? bus1.resp_err : bus2.resp_err;
  endfunction
  function automatic logic [63:0] get_rdata(int sel);
    return (sel == 1) ? bus1.resp_rdata : bus2.resp_rdata;
  endfunction

  task automatic drive(int sel, logic v, logic w, logic [63:0] a, logic [63:0] d);
    if (sel == 1) begin
      bus1.req_valid = v; bus1.req_write = w; bus1.req_addr = a; bus1.req_wdata = d;
    end else begin
      bus2.req_valid = v; bus2.req_write = w; bus2.req_addr = a; bus2.req_wdata = d;
    end
  endtask

  // Reference model: byte address decoded arithmetically, expected response queued.
  task automatic expect_req(int sel, logic w, logic [63:0] a, logic [63:0] d);
    exp_t e;
    logic bad;
    int   idx;
    bad     = ((a % 64'd8) != 64'd0) || (a >= 64'(8 * DEPTH));
    e.err   = bad;
    e.rdata = 64'd0;
    if (!bad) begin
      idx = int'(a / 64'd8);
      if (w) model[sel][idx] = d;
      else   e.rdata = model[sel][idx];
    end
    sb.push_back(e);
  endtask

  // Issue one request and observe its response; lat = -1 on timeout.
  task automatic issue_req(int sel, logic w, logic [63:0] a, logic [63:0] d,
                           output int lat, output logic [63:0] rd,
                           output logic er, output logic after_ok);
    int t;
    @(negedge clk);
    drive(sel, 1'b1, w, a, d);
    t = 0;
    while (!get_ready(sel) && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!get_ready(sel)) begin
      drive(sel, 1'b0, 1'b0, 64'd0, 64'd0);
      lat = -1; rd = 64'd0; er = 1'b0; after_ok = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 1'b0, 64'd0, 64'd0);
    lat = 1;
    while (!get_valid(sel) && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!get_valid(sel)) lat = -1;
    rd = get_rdata(sel);
    er = get_err(sel);
    @(posedge clk);
    #1;
    after_ok = !get_valid(sel) && (get_rdata(sel) == 64'd0) && !get_err(sel);
  endtask

  task automatic test_reset();
    rst2 = 1'b1; rst1 = 1'b1;
    drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(1, 1'b0, 1'b0, 64'd0, 64'd0);
    #1;
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if ({get_ready(s), get_valid(s), get_busy(s), get_err(s), get_rdata(s)} !== 68'd0) begin
        n_errors++;
        $display("FAIL reset_outputs dut%0d: rdy=%b vld=%b busy=%b err=%b rdata=%h, want all 0",
                 s, get_ready(s), get_valid(s), get_busy(s), get_err(s), get_rdata(s));
      end
    end
    repeat (2) @(negedge clk);
    rst2 = 1'b0; rst1 = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if ({get_ready(s), get_busy(s)} !== 2'b10) begin
        n_errors++;
        $display("FAIL reset_release dut%0d: rdy=%b busy=%b, want rdy=1 busy=0",
                 s, get_ready(s), get_busy(s));
      end
    end
  endtask

  task automatic test_preload();
    req_t         rq [$];
    int           lat;
    logic [63:0]  rd;
    logic         er, after_ok;
    exp_t         e;
    logic [63:0]  addrs [6];
    addrs[0] = 64'h0;  addrs[1] = 64'h8;  addrs[2] = 64'h10;
    addrs[3] = 64'h18; addrs[4] = 64'h20; addrs[5] = 64'h3F8;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 6; i++) rq.push_back(mk(s, 1'b1, addrs[i], 64'd0));
    foreach (rq[i]) begin
      expect_req(rq[i].sel, rq[i].w, rq[i].a, rq[i].d);
      issue_req(rq[i].sel, rq[i].w, rq[i].a, rq[i].d, lat, rd, er, after_ok);
      e = sb.pop_front();
      n_checks++;
      if (lat != ((rq[i].sel == 1) ? 1 : 2) || {er, rd} !== {e.err, e.rdata}) begin
        n_errors++;
        $display("FAIL preload[%0d]: lat=%0d err=%b rdata=%h, want lat=%0d err=%b rdata=%h",
                 i, lat, er, rd, (rq[i].sel == 1) ? 1 : 2, e.err, e.rdata);
      end
    end
  endtask

  task automatic test_write_read();
    req_t         rq [$];
    int           lat;
    logic [63:0]  rd;
    logic         er, after_ok;
    exp_t         e;
    rq.push_back(mk(0, 1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D));
    rq.push_back(mk(0, 1'b0, 64'h10, 64'd0));
    rq.push_back(mk(0, 1'b1, 64'h18, 64'h0123_4567_89AB_CDEF));
    rq.push_back(mk(0, 1'b0, 64'h18, 64'd0));
    rq.push_back(mk(0, 1'b0, 64'h10, 64'd0));
    foreach (rq[i]) begin
      expect_req(rq[i].sel, rq[i].w, rq[i].a, rq[i].d);
      issue_req(rq[i].sel, rq[i].w, rq[i].a, rq[i].d, lat, rd, er, after_ok);
      e = sb.pop_front();
      n_checks++;
      if (lat != 2) begin
        n_errors++;
        $display("FAIL wr_rd_latency[%0d]: got %0d cycles, want 2", i, lat);
      end
      n_checks++;
      if ({er, rd} !== {e.err, e.rdata}) begin
        n_errors++;
        $display("FAIL wr_rd_resp[%0d]: err=%b rdata=%h, want err=%b rdata=%h",
                 i, er, rd, e.err, e.rdata);
      end
      n_checks++;
      if (!after_ok) begin
        n_errors++;
        $display("FAIL wr_rd_one_cycle[%0d]: response still present after one cycle, want cleared", i);
      end
    end
  endtask

  task automatic test_misaligned();
    req_t         rq [$];
    int           lat;
    logic [63:0]  rd;
    logic         er, after_ok;
    exp_t         e;
    rq.push_back(mk(0, 1'b1, 64'h08, 64'h0000_0000_0000_A5A5));
    rq.push_back(mk(0, 1'b0, 64'h0B, 64'd0));
    rq.push_back(mk(0, 1'b1, 64'h0B, 64'h55));
    rq.push_back(mk(0, 1'b1, 64'h0C, 64'h66));
    rq.push_back(mk(0, 1'b0, 64'h08, 64'd0));
    foreach (rq[i]) begin
      expect_req(rq[i].sel, rq[i].w, rq[i].a, rq[i].d);
      issue_req(rq[i].sel, rq[i].w, rq[i].a, rq[i].d, lat, rd, er, after_ok);
      e = sb.pop_front();
      n_checks++;
      if (lat != 2 || {er, rd} !== {e.err, e.rdata} || !after_ok) begin
        n_errors++;
        $display("FAIL misaligned[%0d]: lat=%0d err=%b rdata=%h clr=%b, want lat=2 err=%b rdata=%h clr=1",
                 i, lat, er, rd, after_ok, e.err, e.rdata);
      end
    end
  endtask

  task automatic test_out_of_range();
    req_t         rq [$];
    int           lat;
    logic [63:0]  rd;
    logic         er, after_ok;
    exp_t         e;
    rq.push_back(mk(0, 1'b0, 64'h400, 64'd0));
    rq.push_back(mk(0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0));
    rq.push_back(mk(0, 1'b1, 64'h400, 64'h999));
    rq.push_back(mk(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h777));
    rq.push_back(mk(0, 1'b0, 64'h0, 64'd0));
    rq.push_back(mk(0, 1'b0, 64'h3F8, 64'd0));
    foreach (rq[i]) begin
      expect_req(rq[i].sel, rq[i].w, rq[i].a, rq[i].d);
      issue_req(rq[i].sel, rq[i].w, rq[i].a, rq[i].d, lat, rd, er, after_ok);
      e = sb.pop_front();
      n_checks++;
      if (lat != 2 || {er, rd} !== {e.err, e.rdata} || !after_ok) begin
        n_errors++;
        $display("FAIL out_of_range[%0d]: lat=%0d err=%b rdata=%h clr=%b, want lat=2 err=%b rdata=%h clr=1",
                 i, lat, er, rd, after_ok, e.err, e.rdata);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a;
    int          acc_cyc [$];
    logic        rdy;
    exp_t        e;
    int          t;
    a = 64'h0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      drive(0, 1'b1, 1'b0, a, 64'd0);
      rdy = bus2.req_ready;
      n_checks++;
      if (rdy !== !bus2.busy) begin
        n_errors++;
        $display("FAIL b2b_ready_vs_busy c%0d: rdy=%b busy=%b, want rdy = !busy", c, rdy, bus2.busy);
      end
      if (rdy) expect_req(0, 1'b0, a, 64'd0);
      @(posedge clk);
      #1;
      if (rdy) begin
        acc_cyc.push_back(c);
        a = (a == 64'h0) ? 64'h8 : 64'h0;
      end
      if (bus2.resp_valid) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++;
          $display("FAIL b2b_unexpected_resp c%0d: resp_valid=1, want no response", c);
        end else begin
          e = sb.pop_front();
          if ({bus2.resp_err, bus2.resp_rdata} !== {e.err, e.rdata}) begin
            n_errors++;
            $display("FAIL b2b_resp c%0d: err=%b rdata=%h, want err=%b rdata=%h",
                     c, bus2.resp_err, bus2.resp_rdata, e.err, e.rdata);
          end
        end
      end
    end
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
    t = 0;
    while (sb.size() != 0 && t < 10) begin
      @(posedge clk);
      #1;
      t++;
      if (bus2.resp_valid) begin
        e = sb.pop_front();
        n_checks++;
        if ({bus2.resp_err, bus2.resp_rdata} !== {e.err, e.rdata}) begin
          n_errors++;
          $display("FAIL b2b_drain_resp: err=%b rdata=%h, want err=%b rdata=%h",
                   bus2.resp_err, bus2.resp_rdata, e.err, e.rdata);
        end
      end
    end
    n_checks++;
    if (sb.size() != 0 || acc_cyc.size() != 10) begin
      n_errors++;
      $display("FAIL b2b_count: accepts=%0d pending=%0d, want accepts=10 pending=0",
               acc_cyc.size(), sb.size());
      sb.delete();
    end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      n_checks++;
      if (acc_cyc[i] - acc_cyc[i-1] != 3) begin
        n_errors++;
        $display("FAIL b2b_spacing[%0d]: got %0d cycles, want 3", i, acc_cyc[i] - acc_cyc[i-1]);
      end
    end
  endtask

  task automatic test_reset_abort();
    req_t         rq [$];
    int           lat;
    logic [63:0]  rd;
    logic         er, after_ok;
    exp_t         e;
    logic         saw_resp;
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 64'h20, 64'h1234);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
    n_checks++;
    if (bus2.busy !== 1'b1) begin
      n_errors++;
      $display("FAIL abort_accepted: busy=%b, want 1", bus2.busy);
    end
    #1;
    rst2 = 1'b1;
    #1;
    n_checks++;
    if ({bus2.req_ready, bus2.resp_valid, bus2.busy, bus2.resp_err, bus2.resp_rdata} !== 68'd0) begin
      n_errors++;
      $display("FAIL abort_outputs: rdy=%b vld=%b busy=%b err=%b rdata=%h, want all 0",
               bus2.req_ready, bus2.resp_valid, bus2.busy, bus2.resp_err, bus2.resp_rdata);
    end
    saw_resp = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus2.resp_valid) saw_resp = 1'b1;
    end
    @(negedge clk);
    rst2 = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus2.resp_valid) saw_resp = 1'b1;
    end
    n_checks++;
    if (saw_resp) begin
      n_errors++;
      $display("FAIL abort_no_resp: resp_valid=1 seen, want 0");
    end
    rq.push_back(mk(0, 1'b0, 64'h20, 64'd0));
    foreach (rq[i]) begin
      expect_req(rq[i].sel, rq[i].w, rq[i].a, rq[i].d);
      issue_req(rq[i].sel, rq[i].w, rq[i].a, rq[i].d, lat, rd, er, after_ok);
      e = sb.pop_front();
      n_checks++;
      if (lat != 2 || {er, rd} !== {e.err, e.rdata}) begin
        n_errors++;
        $display("FAIL abort_read_back: lat=%0d err=%b rdata=%h, want lat=2 err=%b rdata=%h",
                 lat, er, rd, e.err, e.rdata);
      end
    end
  endtask

  task automatic test_latency1();
    req_t         rq [$];
    int           lat;
    logic [63:0]  rd;
    logic         er, after_ok;
    exp_t         e;
    rq.push_back(mk(1, 1'b1, 64'h18, 64'h7));
    rq.push_back(mk(1, 1'b0, 64'h18, 64'd0));
    rq.push_back(mk(1, 1'b1, 64'h1B, 64'h9));
    rq.push_back(mk(1, 1'b0, 64'h400, 64'd0));
    rq.push_back(mk(1, 1'b0, 64'h18, 64'd0));
    foreach (rq[i]) begin
      expect_req(rq[i].sel, rq[i].w, rq[i].a, rq[i].d);
      issue_req(rq[i].sel, rq[i].w, rq[i].a, rq[i].d, lat, rd, er, after_ok);
      e = sb.pop_front();
      n_checks++;
      if (lat != 1) begin
        n_errors++;
        $display("FAIL lat1_latency[%0d]: got %0d cycles, want 1", i, lat);
      end
      n_checks++;
      if ({er, rd} !== {e.err, e.rdata} || !after_ok) begin
        n_errors++;
        $display("FAIL lat1_resp[%0d]: err=%b rdata=%h clr=%b, want err=%b rdata=%h clr=1",
                 i, er, rd, after_ok, e.err, e.rdata);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < DEPTH; i++) model[s][i] = 64'd0;
    test_reset();
    test_preload();
    test_write_read();
    test_misaligned();
    test_out_of_range();
    test_back_to_back();
    test_reset_abort();
    test_latency1();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, want completion before 500000");
    $fatal(1);
  end

endmodule
